adbg_top_sel: RTL and testbench

- Parametrised debug-module selector and TDO router for the advanced debug interface.
- Runs in the TCK domain behind the TAP, ahead of N debug modules (LINT/AXI bus, CPU, and so on).
- Owns the shared DR shift register, decodes select commands into a one-hot module select, and routes the selected module's TDO.
- Generalises the fixed two-module top:
  - Any module count.
  - Range-checked module IDs with a sticky error flag.
  - A capturable status word that is shifted out when no valid module is selected.

---
 rtl/adbg_pkg.sv | 22 ++
 rtl/adbg_top_sel_if.sv | 20 ++
 rtl/adbg_tdo_mux.sv | 31 +++
 rtl/adbg_top_sel.sv | 112 +++++++++++
 tb/tb_adbg_top_sel.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adbg_pkg.sv
// Shared constants for the advanced debug interface module selector:
// default widths, select-command bit position and status word layout.
package adbg_pkg;

    localparam int DEF_NUM_MODULES     = 3;
    localparam int DEF_MODULE_ID_WIDTH = 5;
    localparam int DEF_SHIFT_WIDTH     = 64;

    // The select-command flag sits in the MSB of the DR shift register.
    function automatic int cmd_bit_pos(input int shift_width);
        return shift_width - 1;
    endfunction

    function automatic int status_err_bit(input int id_width);
        return id_width + 1;
    endfunction

    function automatic int status_valid_bit(input int id_width);
        return id_width;
    endfunction

endpackage

// File: rtl/adbg_top_sel_if.sv
// TAP-side serial/control bundle between the JTAG TAP controller and the
// debug-module selector.
interface adbg_top_sel_if;
    logic tdi_i;
    logic tdo_o;
    logic debug_select_i;
    logic capture_dr_i;
    logic shift_dr_i;
    logic update_dr_i;

    modport master (
        output tdi_i, debug_select_i, capture_dr_i, shift_dr_i, update_dr_i,
        input  tdo_o
    );

    modport slave (
        input  tdi_i, debug_select_i, capture_dr_i, shift_dr_i, update_dr_i,
        output tdo_o
    );
endinterface

// File: rtl/adbg_tdo_mux.sv
// N:1 TDO router: selected module TDO when a valid selection exists, status bit otherwise.
// Define ADBG_TOP_SEL_TDO_REG_EN to register the output (1 TCK latency, resets to 0).
module adbg_tdo_mux #(
    parameter int NUM_MODULES = adbg_pkg::DEF_NUM_MODULES
) (
`ifdef ADBG_TOP_SEL_TDO_REG_EN
    input  logic                   tck_i,
    input  logic                   trst_i,
`endif
    input  logic [NUM_MODULES-1:0] sel_onehot,
    input  logic [NUM_MODULES-1:0] module_tdo,
    input  logic                   sel_valid,
    input  logic                   status_bit,
    output logic                   tdo
);

    logic tdo_mux;

    // sel_onehot is all-zero unless sel_valid, so AND-OR is an exact N:1 mux.
    assign tdo_mux = sel_valid ? |(module_tdo & sel_onehot) : status_bit;

`ifdef ADBG_TOP_SEL_TDO_REG_EN
    always_ff @(posedge tck_i) begin
        if (trst_i) tdo <= 1'b0;
        else        tdo <= tdo_mux;
    end
`else
    assign tdo = tdo_mux;
`endif

endmodule

// File: rtl/adbg_top_sel.sv
// Debug-module selector: owns the shared DR shift register, decodes select commands
// into a one-hot module select, and routes TDO. Optional macro: ADBG_TOP_SEL_TDO_REG_EN.
module adbg_top_sel
    import adbg_pkg::*;
#(
    parameter int NUM_MODULES     = DEF_NUM_MODULES,
    parameter int MODULE_ID_WIDTH = DEF_MODULE_ID_WIDTH,
    parameter int SHIFT_WIDTH     = DEF_SHIFT_WIDTH
) (
    input  logic                       tck_i,
    input  logic                       trst_i,
    adbg_top_sel_if.slave              tap,
    output logic [SHIFT_WIDTH-1:0]     data_register_o,
    output logic [NUM_MODULES-1:0]     module_select_o,
    input  logic [NUM_MODULES-1:0]     module_tdo_i,
    input  logic [NUM_MODULES-1:0]     module_inhibit_i,
    output logic [MODULE_ID_WIDTH-1:0] module_id_o,
    output logic                       sel_err_o
);

    localparam int CMD_BIT   = cmd_bit_pos(SHIFT_WIDTH);
    localparam int ERR_BIT   = status_err_bit(MODULE_ID_WIDTH);
    localparam int VALID_BIT = status_valid_bit(MODULE_ID_WIDTH);
    localparam int STAT_W    = MODULE_ID_WIDTH + 2;

    localparam logic [MODULE_ID_WIDTH:0] NUM_MOD_W = (MODULE_ID_WIDTH+1)'(NUM_MODULES);

    logic [SHIFT_WIDTH-1:0]     sr;
    logic [STAT_W-1:0]          stat;
    logic [STAT_W-1:0]          stat_capture;
    logic [MODULE_ID_WIDTH-1:0] id_field;
    logic                       sel_valid;
    logic                       do_shift;
    logic                       do_capture;
    logic                       sel_req;
    logic                       id_in_range;

    assign do_shift   = tap.debug_select_i && tap.shift_dr_i;
    assign do_capture = tap.debug_select_i && tap.capture_dr_i;

    // Decoded from the pre-edge register so a coincident (illegal) shift does not corrupt it.
    assign id_field    = sr[CMD_BIT-1 -: MODULE_ID_WIDTH];
    assign id_in_range = {1'b0, id_field} < NUM_MOD_W;
    assign sel_req     = tap.debug_select_i && tap.update_dr_i && sr[CMD_BIT]
                         && !(|module_inhibit_i);

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            sr <= '0;
        end else if (do_shift) begin
            sr <= {tap.tdi_i, sr[SHIFT_WIDTH-1:1]};
        end
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            module_id_o <= '0;
            sel_valid   <= 1'b0;
            sel_err_o   <= 1'b0;
        end else if (sel_req) begin
            if (id_in_range) begin
                module_id_o <= id_field;
                sel_valid   <= 1'b1;
                sel_err_o   <= 1'b0;
            end else begin
                sel_valid   <= 1'b0;
                sel_err_o   <= 1'b1;
            end
        end
    end

    always_comb begin
        stat_capture                      = '0;
        stat_capture[ERR_BIT]             = sel_err_o;
        stat_capture[VALID_BIT]           = sel_valid;
        stat_capture[MODULE_ID_WIDTH-1:0] = module_id_o;
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            stat <= '0;
        end else if (do_capture) begin
            stat <= stat_capture;
        end else if (do_shift) begin
            stat <= {1'b0, stat[STAT_W-1:1]};
        end
    end

    always_comb begin
        module_select_o = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            module_select_o[i] = sel_valid && (module_id_o == MODULE_ID_WIDTH'(i));
        end
    end

    assign data_register_o = sr;

    adbg_tdo_mux #(
        .NUM_MODULES (NUM_MODULES)
    ) u_tdo_mux (
`ifdef ADBG_TOP_SEL_TDO_REG_EN
        .tck_i       (tck_i),
        .trst_i      (trst_i),
`endif
        .sel_onehot  (module_select_o),
        .module_tdo  (module_tdo_i),
        .sel_valid   (sel_valid),
        .status_bit  (stat[0]),
        .tdo         (tap.tdo_o)
    );

endmodule

// File: tb/tb_adbg_top_sel.sv
// Scoreboard bench for adbg_top_sel (NUM_MODULES=3, MODULE_ID_WIDTH=5, SHIFT_WIDTH=64),
// default build with the combinational TDO path.
module tb_adbg_top_sel;

    localparam int N   = 3;
    localparam int IDW = 5;
    localparam int SW  = 64;

    localparam int K_SEL = 0;
    localparam int K_ID  = 1;
    localparam int K_ERR = 2;
    localparam int K_TDO = 3;
    localparam int K_DR  = 4;

    typedef struct {
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic           tck = 1'b0;
    logic           trst;
    logic [SW-1:0]  data_register;
    logic [N-1:0]   module_select;
    logic [N-1:0]   module_tdo;
    logic [N-1:0]   module_inhibit;
    logic [IDW-1:0] module_id;
    logic           sel_err;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    adbg_top_sel_if tap_if ();

    adbg_top_sel #(
        .NUM_MODULES     (N),
        .MODULE_ID_WIDTH (IDW),
        .SHIFT_WIDTH     (SW)
    ) dut (
        .tck_i            (tck),
        .trst_i           (trst),
        .tap              (tap_if),
        .data_register_o  (data_register),
        .module_select_o  (module_select),
        .module_tdo_i     (module_tdo),
        .module_inhibit_i (module_inhibit),
        .module_id_o      (module_id),
        .sel_err_o        (sel_err)
    );

    always #5 tck = ~tck;

    function automatic string kname(input int k);
        case (k)
            K_SEL:   return "module_select";
            K_ID:    return "module_id";
            K_ERR:   return "sel_err";
            K_TDO:   return "tdo";
            default: return "data_register";
        endcase
    endfunction

    // Monitor: compares every pending expectation against the outputs at the falling edge.
    always @(negedge tck) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.kind)
                K_SEL:   act = 64'(module_select);
                K_ID:    act = 64'(module_id);
                K_ERR:   act = 64'(sel_err);
                K_TDO:   act = 64'(tap_if.tdo_o);
                default: act = data_register;
            endcase
            n_chk++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got %0h expected %0h at %0t", kname(e.kind), act, e.val, $time);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [63:0] v);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic expect_sel(input logic [N-1:0] s, input logic [IDW-1:0] id, input logic err);
        expect_val(K_SEL, 64'(s));
        expect_val(K_ID, 64'(id));
        expect_val(K_ERR, 64'(err));
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    function automatic logic [SW-1:0] make_cmd(input logic cmd, input logic [IDW-1:0] id);
        logic [SW-1:0] w;
        w = '0;
        w[SW-1] = cmd;
        w[SW-2 -: IDW] = id;
        w[7:0] = 8'hA5;
        return w;
    endfunction

    task automatic shift_bits(input logic [SW-1:0] w, input int nbits);
        tap_if.debug_select_i = 1'b1;
        tap_if.shift_dr_i     = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            tap_if.tdi_i = w[i];
            tick();
        end
        tap_if.shift_dr_i = 1'b0;
        tap_if.tdi_i      = 1'b0;
    endtask

    task automatic pulse_update();
        tap_if.update_dr_i = 1'b1;
        tick();
        tap_if.update_dr_i = 1'b0;
    endtask

    task automatic do_select(input logic cmd, input logic [IDW-1:0] id);
        shift_bits(make_cmd(cmd, id), SW);
        expect_val(K_DR, make_cmd(cmd, id));
        pulse_update();
    endtask

    logic [6:0] stat_exp;

    initial begin
        trst                  = 1'b1;
        module_tdo            = '0;
        module_inhibit        = '0;
        tap_if.tdi_i          = 1'b0;
        tap_if.debug_select_i = 1'b0;
        tap_if.capture_dr_i   = 1'b0;
        tap_if.shift_dr_i     = 1'b0;
        tap_if.update_dr_i    = 1'b0;
        tick();
        tick();
        expect_sel(3'b000, 5'd0, 1'b0);
        expect_val(K_TDO, 64'd0);
        expect_val(K_DR, 64'd0);
        trst = 1'b0;

        // Valid select of module 2 and TDO routing
        do_select(1'b1, 5'd2);
        expect_sel(3'b100, 5'd2, 1'b0);
        module_tdo = 3'b100;
        expect_val(K_TDO, 64'd1);
        tick();
        module_tdo = 3'b000;
        expect_val(K_TDO, 64'd0);
        tick();
        module_tdo = 3'b001;
        expect_val(K_TDO, 64'd0);
        tick();
        module_tdo = 3'b011;
        expect_val(K_TDO, 64'd0);
        tick();
        module_tdo = 3'b000;

        // Out-of-range select keeps ID, raises error; status word shifted out
        do_select(1'b1, 5'd5);
        expect_sel(3'b000, 5'd2, 1'b1);
        tap_if.capture_dr_i = 1'b1;
        tick();
        tap_if.capture_dr_i = 1'b0;
        stat_exp = 7'b1000010;
        expect_val(K_TDO, 64'(stat_exp[0]));
        for (int k = 1; k < 7; k++) begin
            tap_if.shift_dr_i = 1'b1;
            tick();
            expect_val(K_TDO, 64'(stat_exp[k]));
        end
        tap_if.shift_dr_i = 1'b0;
        tick();

        // Inhibited select is ignored, then accepted once released
        module_inhibit = 3'b001;
        do_select(1'b1, 5'd1);
        expect_sel(3'b000, 5'd2, 1'b1);
        module_inhibit = 3'b000;
        pulse_update();
        expect_sel(3'b010, 5'd1, 1'b0);

        // Module command (cmd bit 0) leaves selector alone
        do_select(1'b0, 5'd7);
        expect_sel(3'b010, 5'd1, 1'b0);

        // Range boundaries: ID 0 is valid, ID 3 is the first invalid one
        do_select(1'b1, 5'd0);
        expect_sel(3'b001, 5'd0, 1'b0);
        do_select(1'b1, 5'd3);
        expect_sel(3'b000, 5'd0, 1'b1);

        // debug_select low: shift/update ignored, selection still visible
        do_select(1'b1, 5'd2);
        expect_sel(3'b100, 5'd2, 1'b0);
        tap_if.debug_select_i = 1'b0;
        tap_if.shift_dr_i     = 1'b1;
        tap_if.tdi_i          = 1'b1;
        tick();
        tick();
        tap_if.shift_dr_i  = 1'b0;
        tap_if.update_dr_i = 1'b1;
        tick();
        tap_if.update_dr_i = 1'b0;
        expect_val(K_DR, make_cmd(1'b1, 5'd2));
        expect_sel(3'b100, 5'd2, 1'b0);

        // Max ID is out of range; then reset in the middle of a shift
        do_select(1'b1, 5'd31);
        expect_sel(3'b000, 5'd2, 1'b1);
        shift_bits(make_cmd(1'b1, 5'd1), 30);
        tap_if.shift_dr_i = 1'b1;
        trst = 1'b1;
        tick();
        trst = 1'b0;
        tap_if.shift_dr_i = 1'b0;
        expect_sel(3'b000, 5'd0, 1'b0);
        expect_val(K_DR, 64'd0);
        expect_val(K_TDO, 64'd0);

        do_select(1'b1, 5'd1);
        expect_sel(3'b010, 5'd1, 1'b0);
        module_tdo = 3'b010;
        expect_val(K_TDO, 64'd1);
        tick();

        for (int w = 0; w < 5 && q.size() > 0; w++) tick();
        if (q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
